// File: rtl/switch_control_if.sv
// ============================================================================
// switch_control_if
// Request/grant and crossbar-table bundle between input buffers and the
// switch controller of one 5-port NoC router.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface switch_control_if #(
    parameter int NPORT   = 5,
    parameter int NP_REGF = 80,
    parameter int NP_REG3 = 15
);
    logic [7:0]         address;
    logic [NPORT-1:0]   h;
    logic [NP_REGF-1:0] data_in_t;
    logic [NPORT-1:0]   sender;
    logic [NPORT-1:0]   ack_h;
    logic [NPORT-1:0]   free;
    logic [NP_REG3-1:0] tab_in_t;
    logic [NP_REG3-1:0] tab_out_t;

    // master: input buffers / crossbar side
    modport master (
        output address,
        output h,
        output data_in_t,
        output sender,
        input  ack_h,
        input  free,
        input  tab_in_t,
        input  tab_out_t
    );

    // slave: the switch controller
    modport slave (
        input  address,
        input  h,
        input  data_in_t,
        input  sender,
        output ack_h,
        output free,
        output tab_in_t,
        output tab_out_t
    );
endinterface

`default_nettype wire

// File: rtl/switch_control.sv
// ============================================================================
// switch_control
// Round-robin arbitration, XY routing and crossbar table programming for a
// 5-port NoC router; releases an output when its owning input stops sending.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_control (
    input  wire logic        clock,
    input  wire logic        reset,
    switch_control_if.slave  bus
);

    localparam int NPORT   = 5;
    localparam int NP_REG3 = 15;

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ROUTE = 2'd2,
        GRANT = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [2:0]         sel_q,     sel_d;
    logic [2:0]         dest_q,    dest_d;
    logic [NPORT-1:0]   ack_q,     ack_d;
    logic [NPORT-1:0]   free_q,    free_d;
    logic [NP_REG3-1:0] tab_in_q,  tab_in_d;
    logic [NP_REG3-1:0] tab_out_q, tab_out_d;

    logic [2:0]         w_arb_sel;
    logic               w_arb_hit;
    logic [7:0]         w_target;
    logic [2:0]         w_route;
    logic [7:0]         w_sender_ext;

    // XY dimension-order routing: resolve X first, then Y, else deliver locally
    function automatic logic [2:0] xy_route(input logic [7:0] local_addr,
                                            input logic [7:0] target);
        logic [3:0] lx;
        logic [3:0] ly;
        logic [3:0] tx;
        logic [3:0] ty;
        logic [2:0] port;
        lx = local_addr[7:4];
        ly = local_addr[3:0];
        tx = target[7:4];
        ty = target[3:0];
        if (tx > lx)      port = EAST;
        else if (tx < lx) port = WEST;
        else if (ty > ly) port = NORTH;
        else if (ty < ly) port = SOUTH;
        else              port = LOCAL;
        return port;
    endfunction

    // Round-robin search: start one past the last selected port and wrap,
    // so the previously selected port is examined last.
    always_comb begin
        logic [3:0] idx;
        w_arb_sel = sel_q;
        w_arb_hit = 1'b0;
        idx       = 4'd0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = {1'b0, sel_q} + 4'(k);
            if (idx >= 4'(NPORT)) begin
                idx = idx - 4'(NPORT);
            end
            if (!w_arb_hit && bus.h[idx[2:0]]) begin
                w_arb_sel = idx[2:0];
                w_arb_hit = 1'b1;
            end
        end
    end

    assign w_target     = bus.data_in_t[{sel_q, 4'b0000} +: 8];
    assign w_route      = xy_route(bus.address, w_target);
    assign w_sender_ext = {3'b000, bus.sender};

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dest_d    = dest_q;
        ack_d     = '0;
        free_d    = free_q;
        tab_in_d  = tab_in_q;
        tab_out_d = tab_out_q;

        // Release is independent of arbitration; stale table entries are
        // harmless because the crossbar gates on free.
        for (int o = 0; o < NPORT; o++) begin
            if (!free_q[o] && !w_sender_ext[tab_out_q[o*3 +: 3]]) begin
                free_d[o] = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                // ack_h mask covers the cycle in which the granted requester
                // is still holding its h bit.
                if ((bus.h & ~ack_q) != '0) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (w_arb_hit) begin
                    sel_d   = w_arb_sel;
                    state_d = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: begin
                dest_d  = w_route;
                state_d = GRANT;
            end
            GRANT: begin
                // A denied port still advances sel, so it cannot starve others.
                if (free_q[dest_q]) begin
                    tab_out_d[dest_q*3 +: 3] = sel_q;
                    tab_in_d[sel_q*3 +: 3]   = dest_q;
                    free_d[dest_q]           = 1'b0;
                    ack_d[sel_q]             = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= LOCAL;
            dest_q    <= EAST;
            ack_q     <= '0;
            free_q    <= '1;
            tab_in_q  <= '0;
            tab_out_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            dest_q    <= dest_d;
            ack_q     <= ack_d;
            free_q    <= free_d;
            tab_in_q  <= tab_in_d;
            tab_out_q <= tab_out_d;
        end
    end

    assign bus.ack_h     = ack_q;
    assign bus.free      = free_q;
    assign bus.tab_in_t  = tab_in_q;
    assign bus.tab_out_t = tab_out_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_control.sv
// ============================================================================
// tb_switch_control
// Directed self-checking bench for switch_control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_control;

    logic clock = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clock = ~clock;

    switch_control_if bus ();

    switch_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input int max_cycles, output int cycles, output logic [4:0] seen);
        cycles = 0;
        seen   = '0;
        while (seen == 5'b0 && cycles < max_cycles) begin
            tick();
            cycles++;
            seen = bus.ack_h;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.address   = 8'h00;
        bus.h         = '0;
        bus.sender    = '0;
        bus.data_in_t = '0;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if (bus.free !== 5'b11111) begin
            tests_failed++;
            $display("FAIL reset_free: got %b expected %b", bus.free, 5'b11111);
        end
        tests_run++;
        if (bus.ack_h !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_ack: got %b expected %b", bus.ack_h, 5'b00000);
        end
        tests_run++;
        if (bus.tab_in_t !== 15'h0000) begin
            tests_failed++;
            $display("FAIL reset_tab_in: got %h expected %h", bus.tab_in_t, 15'h0000);
        end
        tests_run++;
        if (bus.tab_out_t !== 15'h0000) begin
            tests_failed++;
            $display("FAIL reset_tab_out: got %h expected %h", bus.tab_out_t, 15'h0000);
        end
    endtask

    task automatic test_local_request();
        logic [4:0] early;
        bus.address           = 8'h11;
        bus.data_in_t         = '0;
        bus.data_in_t[79:64]  = 16'h0031;
        bus.sender            = 5'b10000;
        bus.h                 = 5'b10000;
        early = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            early |= bus.ack_h;
        end
        tests_run++;
        if (early !== 5'b00000) begin
            tests_failed++;
            $display("FAIL local_ack_early: got %b expected %b", early, 5'b00000);
        end
        tick();
        tests_run++;
        if (bus.ack_h !== 5'b10000) begin
            tests_failed++;
            $display("FAIL local_ack: got %b expected %b", bus.ack_h, 5'b10000);
        end
        tests_run++;
        if (bus.free !== 5'b11110) begin
            tests_failed++;
            $display("FAIL local_free: got %b expected %b", bus.free, 5'b11110);
        end
        tests_run++;
        if (bus.tab_out_t[2:0] !== 3'd4) begin
            tests_failed++;
            $display("FAIL local_tab_out_east: got %0d expected %0d", bus.tab_out_t[2:0], 4);
        end
        tests_run++;
        if (bus.tab_in_t[14:12] !== 3'd0) begin
            tests_failed++;
            $display("FAIL local_tab_in_local: got %0d expected %0d", bus.tab_in_t[14:12], 0);
        end
        bus.h = '0;
        tick();
        tests_run++;
        if (bus.ack_h !== 5'b00000) begin
            tests_failed++;
            $display("FAIL local_ack_pulse: got %b expected %b", bus.ack_h, 5'b00000);
        end
        tests_run++;
        if (bus.free !== 5'b11110) begin
            tests_failed++;
            $display("FAIL local_free_hold: got %b expected %b", bus.free, 5'b11110);
        end
    endtask

    task automatic test_release();
        bus.sender = '0;
        tick();
        tests_run++;
        if (bus.free !== 5'b11111) begin
            tests_failed++;
            $display("FAIL release_free: got %b expected %b", bus.free, 5'b11111);
        end
    endtask

    task automatic test_xy();
        logic [7:0] tgt [6];
        logic [2:0] exp_port [6];
        logic [2:0] e;
        logic [4:0] exp_free;
        logic [4:0] seen;
        int         cyc;
        tgt      = '{8'h32, 8'h12, 8'h23, 8'h21, 8'h22, 8'h33};
        exp_port = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        bus.address = 8'h22;
        for (int i = 0; i < 6; i++) begin
            e                    = exp_port[i];
            exp_free             = 5'b11111 ^ (5'b00001 << e);
            bus.data_in_t        = '0;
            bus.data_in_t[79:64] = {8'h00, tgt[i]};
            bus.h                = 5'b10000;
            bus.sender           = 5'b10000;
            wait_ack(8, cyc, seen);
            tests_run++;
            if (seen !== 5'b10000 || cyc != 4) begin
                tests_failed++;
                $display("FAIL xy_ack[%0d]: got %b after %0d cycles expected %b after 4", i, seen, cyc, 5'b10000);
            end
            tests_run++;
            if (bus.tab_in_t[14:12] !== e) begin
                tests_failed++;
                $display("FAIL xy_tab_in[%0d]: got %0d expected %0d", i, bus.tab_in_t[14:12], e);
            end
            tests_run++;
            if (bus.tab_out_t[e*3 +: 3] !== 3'd4) begin
                tests_failed++;
                $display("FAIL xy_tab_out[%0d]: got %0d expected %0d", i, bus.tab_out_t[e*3 +: 3], 4);
            end
            tests_run++;
            if (bus.free !== exp_free) begin
                tests_failed++;
                $display("FAIL xy_free[%0d]: got %b expected %b", i, bus.free, exp_free);
            end
            bus.h      = '0;
            bus.sender = '0;
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] seen;
        int         cyc;
        bus.address   = 8'h22;
        bus.data_in_t = {16'h0022, 16'h0021, 16'h0023, 16'h0012, 16'h0032};
        bus.sender    = 5'b11111;
        bus.h         = 5'b11111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(8, cyc, seen);
            tests_run++;
            if (seen !== (5'b00001 << g)) begin
                tests_failed++;
                $display("FAIL rr_order[%0d]: got %b expected %b", g, seen, 5'b00001 << g);
            end
            tests_run++;
            if (cyc != 4) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got %0d cycles expected 4", g, cyc);
            end
            bus.h[g] = 1'b0;
        end
        tests_run++;
        if (bus.free !== 5'b00000) begin
            tests_failed++;
            $display("FAIL rr_all_busy: got %b expected %b", bus.free, 5'b00000);
        end
        tests_run++;
        if (bus.tab_in_t !== 15'b100_011_010_001_000 || bus.tab_out_t !== 15'b100_011_010_001_000) begin
            tests_failed++;
            $display("FAIL rr_tabs: got in=%b out=%b expected %b", bus.tab_in_t, bus.tab_out_t, 15'b100_011_010_001_000);
        end
        bus.sender = '0;
        tick();
        tests_run++;
        if (bus.free !== 5'b11111) begin
            tests_failed++;
            $display("FAIL rr_release_all: got %b expected %b", bus.free, 5'b11111);
        end
        bus.h      = 5'b11111;
        bus.sender = 5'b11111;
        wait_ack(8, cyc, seen);
        tests_run++;
        if (seen !== 5'b00001) begin
            tests_failed++;
            $display("FAIL rr_wrap: got %b expected %b", seen, 5'b00001);
        end
        bus.h[0] = 1'b0;
        wait_ack(8, cyc, seen);
        tests_run++;
        if (seen !== 5'b00010) begin
            tests_failed++;
            $display("FAIL rr_wrap_next: got %b expected %b", seen, 5'b00010);
        end
        bus.h      = '0;
        bus.sender = '0;
        tick();
        tick();
    endtask

    task automatic test_contention();
        logic [4:0] seen;
        logic [4:0] any_ack;
        int         cyc;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.address          = 8'h22;
        bus.data_in_t        = '0;
        bus.data_in_t[31:16] = 16'h0032;
        bus.data_in_t[47:32] = 16'h0032;
        bus.sender           = 5'b00110;
        bus.h                = 5'b00110;
        wait_ack(8, cyc, seen);
        tests_run++;
        if (seen !== 5'b00010) begin
            tests_failed++;
            $display("FAIL cont_first: got %b expected %b", seen, 5'b00010);
        end
        bus.h[1] = 1'b0;
        any_ack  = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            any_ack |= bus.ack_h;
        end
        tests_run++;
        if (any_ack !== 5'b00000) begin
            tests_failed++;
            $display("FAIL cont_deny_ack: got %b expected %b", any_ack, 5'b00000);
        end
        tests_run++;
        if (bus.free !== 5'b11110) begin
            tests_failed++;
            $display("FAIL cont_deny_free: got %b expected %b", bus.free, 5'b11110);
        end
        bus.sender[1] = 1'b0;
        tick();
        tests_run++;
        if (bus.free !== 5'b11111) begin
            tests_failed++;
            $display("FAIL cont_release: got %b expected %b", bus.free, 5'b11111);
        end
        wait_ack(5, cyc, seen);
        tests_run++;
        if (seen !== 5'b00100) begin
            tests_failed++;
            $display("FAIL cont_second: got %b expected %b", seen, 5'b00100);
        end
        tests_run++;
        if (bus.tab_out_t[2:0] !== 3'd2 || bus.tab_in_t[8:6] !== 3'd0) begin
            tests_failed++;
            $display("FAIL cont_tabs: got out0=%0d in2=%0d expected out0=2 in2=0", bus.tab_out_t[2:0], bus.tab_in_t[8:6]);
        end
        bus.h      = '0;
        bus.sender = '0;
        tick();
        tests_run++;
        if (bus.free !== 5'b11111) begin
            tests_failed++;
            $display("FAIL cont_final_release: got %b expected %b", bus.free, 5'b11111);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] seen;
        int         cyc;
        bus.address          = 8'h22;
        bus.data_in_t        = '0;
        bus.data_in_t[63:48] = 16'h0021;
        bus.data_in_t[79:64] = 16'h0022;
        bus.sender           = 5'b11000;
        bus.h                = 5'b01000;
        wait_ack(8, cyc, seen);
        tests_run++;
        if (seen !== 5'b01000) begin
            tests_failed++;
            $display("FAIL mid_setup_ack: got %b expected %b", seen, 5'b01000);
        end
        bus.h = '0;
        tick();
        bus.h = 5'b10000;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.free !== 5'b10111) begin
            tests_failed++;
            $display("FAIL mid_pre_reset_free: got %b expected %b", bus.free, 5'b10111);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (bus.free !== 5'b11111 || bus.ack_h !== 5'b00000) begin
            tests_failed++;
            $display("FAIL mid_reset_free_ack: got free=%b ack=%b expected free=11111 ack=00000", bus.free, bus.ack_h);
        end
        tests_run++;
        if (bus.tab_in_t !== 15'h0000 || bus.tab_out_t !== 15'h0000) begin
            tests_failed++;
            $display("FAIL mid_reset_tabs: got in=%h out=%h expected 0", bus.tab_in_t, bus.tab_out_t);
        end
        reset = 1'b0;
        wait_ack(8, cyc, seen);
        tests_run++;
        if (seen !== 5'b10000 || cyc != 4) begin
            tests_failed++;
            $display("FAIL mid_regrant: got %b after %0d cycles expected %b after 4", seen, cyc, 5'b10000);
        end
        tests_run++;
        if (bus.free !== 5'b01111 || bus.tab_in_t[14:12] !== 3'd4 || bus.tab_out_t[14:12] !== 3'd4) begin
            tests_failed++;
            $display("FAIL mid_regrant_state: got free=%b in4=%0d out4=%0d expected free=01111 in4=4 out4=4",
                     bus.free, bus.tab_in_t[14:12], bus.tab_out_t[14:12]);
        end
        bus.h      = '0;
        bus.sender = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_local_request();
        test_release();
        test_xy();
        test_round_robin();
        test_contention();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
